puc_cpu: RTL and testbench



---
 rtl/puc_pkg.sv | 63 ++++++
 rtl/puc_alu.sv | 29 ++
 rtl/puc_cpu.sv | 89 ++++++++
 tb/tb_puc_cpu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/puc_pkg.sv
// rtl/puc_pkg.sv - shared widths, opcodes, field positions and default ROM for puc_cpu
package puc_pkg;

    localparam int REGISTER_WIDTH = 8;
    localparam int PC_WIDTH       = 4;
    localparam int INSTR_WIDTH    = 16;
    localparam int ROM_DEPTH      = 2 ** PC_WIDTH;

    // Instruction fields: op[15:12] rd[11:10] rs[9:8] imm[7:0]
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // All 16 codes are listed so any 4-bit field casts to a named value.
    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LDI    = 4'h1,
        OP_ADD    = 4'h2,
        OP_SUB    = 4'h3,
        OP_AND    = 4'h4,
        OP_OR     = 4'h5,
        OP_XOR    = 4'h6,
        OP_MOV    = 4'h7,
        OP_ADDI   = 4'h8,
        OP_IN     = 4'h9,
        OP_JMP    = 4'hA,
        OP_JZ     = 4'hB,
        OP_JNZ    = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_RSVD_E = 4'hE,
        OP_HALT   = 4'hF
    } op_t;

    typedef logic [ROM_DEPTH-1:0][INSTR_WIDTH-1:0] rom_t;

    function automatic logic [INSTR_WIDTH-1:0] encode(op_t op, logic [1:0] rd,
                                                      logic [1:0] rs, logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Up/down counter on r1 steered by the switch; unused words are NOP.
    function automatic rom_t default_rom();
        rom_t r;
        r    = '0;
        r[0] = encode(OP_LDI, 2'd1, 2'd0, 8'd0);
        r[1] = encode(OP_LDI, 2'd2, 2'd0, 8'd1);
        r[2] = encode(OP_IN,  2'd3, 2'd0, 8'd0);
        r[3] = encode(OP_JNZ, 2'd0, 2'd3, 8'd6);
        r[4] = encode(OP_ADD, 2'd1, 2'd2, 8'd0);
        r[5] = encode(OP_JMP, 2'd0, 2'd0, 8'd2);
        r[6] = encode(OP_SUB, 2'd1, 2'd2, 8'd0);
        r[7] = encode(OP_JMP, 2'd0, 2'd0, 8'd2);
        return r;
    endfunction

    localparam rom_t ROM_INIT = default_rom();

endpackage

// File: rtl/puc_alu.sv
// rtl/puc_alu.sv - combinational ALU for puc_cpu
// Ports: op (opcode), a (rd value), b (rs value), imm (immediate), result (value to write to rd)
module puc_alu
    import puc_pkg::*;
(
    input  op_t                       op,
    input  logic [REGISTER_WIDTH-1:0] a,
    input  logic [REGISTER_WIDTH-1:0] b,
    input  logic [7:0]                imm,
    output logic [REGISTER_WIDTH-1:0] result
);

    // Arithmetic wraps modulo 2**REGISTER_WIDTH by truncation.
    always_comb begin
        result = a;
        case (op)
            OP_LDI:  result = REGISTER_WIDTH'(imm);
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_MOV:  result = b;
            OP_ADDI: result = a + REGISTER_WIDTH'(imm);
            default: result = a;
        endcase
    end

endmodule

// File: rtl/puc_cpu.sv
// rtl/puc_cpu.sv - single-cycle Harvard CPU with internal ROM and 4-entry register file
// Ports: clock (rising edge), isReset (sync active-high), switch (read by IN),
//        register1Value (contents of r1, straight from the register)
module puc_cpu
    import puc_pkg::*;
#(
    parameter rom_t ROM = ROM_INIT
) (
    input  logic                      clock,
    input  logic                      isReset,
    input  logic                      switch,
    output logic [REGISTER_WIDTH-1:0] register1Value
);

    logic [PC_WIDTH-1:0]       pc;
    logic [PC_WIDTH-1:0]       pc_next;
    logic [REGISTER_WIDTH-1:0] regs [4];

    logic [INSTR_WIDTH-1:0]    instr;
    op_t                       op;
    logic [1:0]                rd;
    logic [1:0]                rs;
    logic [7:0]                imm;
    logic [REGISTER_WIDTH-1:0] rd_val;
    logic [REGISTER_WIDTH-1:0] rs_val;
    logic [REGISTER_WIDTH-1:0] alu_result;
    logic [REGISTER_WIDTH-1:0] wr_data;
    logic                      wr_en;

    assign instr  = ROM[pc];
    assign op     = op_t'(instr[OP_MSB:OP_LSB]);
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];

    puc_alu u_alu (
        .op     (op),
        .a      (rd_val),
        .b      (rs_val),
        .imm    (imm),
        .result (alu_result)
    );

    // Register write-back; IN bypasses the ALU since it only needs the switch level.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_result;
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_MOV, OP_ADDI: wr_en = 1'b1;
            OP_IN: begin
                wr_en   = 1'b1;
                wr_data = REGISTER_WIDTH'(switch);
            end
            default: wr_en = 1'b0;
        endcase
    end

    // Branch targets use only the low PC_WIDTH bits of imm; HALT re-executes itself forever.
    always_comb begin
        pc_next = pc + PC_WIDTH'(1);
        case (op)
            OP_JMP:  pc_next = imm[PC_WIDTH-1:0];
            OP_JZ:   if (rs_val == '0) pc_next = imm[PC_WIDTH-1:0];
            OP_JNZ:  if (rs_val != '0) pc_next = imm[PC_WIDTH-1:0];
            OP_HALT: pc_next = pc;
            default: pc_next = pc + PC_WIDTH'(1);
        endcase
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            pc <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc <= pc_next;
            if (wr_en) begin
                regs[rd] <= wr_data;
            end
        end
    end

    assign register1Value = regs[1];

endmodule

// File: tb/tb_puc_cpu.sv
// tb/tb_puc_cpu.sv - self-checking bench for puc_cpu
module tb_puc_cpu;
    import puc_pkg::*;

    logic       clock = 1'b0;
    logic       isReset = 1'b1;
    logic       switch = 1'b0;
    logic [7:0] register1Value;

    logic       isa_reset = 1'b1;
    logic       isa_switch = 1'b0;
    logic [7:0] isa_r1;

    int checks = 0;
    int errors = 0;

    // Program-level model of the counter: after release, edge 3+4n samples the
    // switch and edge 5+4n applies +1 (switch was 0) or -1 (switch was 1) to r1.
    int       m_edges = 0;
    logic     m_dir = 1'b0;
    logic [7:0] m_r1 = 8'd0;

    function automatic rom_t isa_rom();
        rom_t r;
        r    = '0;
        r[0] = encode(OP_LDI,  2'd1, 2'd0, 8'hFF);
        r[1] = encode(OP_ADDI, 2'd1, 2'd0, 8'h01);
        r[2] = encode(OP_JZ,   2'd0, 2'd1, 8'd5);
        r[3] = encode(OP_LDI,  2'd1, 2'd0, 8'hEE);
        r[4] = encode(OP_NOP,  2'd0, 2'd0, 8'h00);
        r[5] = encode(OP_LDI,  2'd2, 2'd0, 8'h01);
        r[6] = encode(OP_JZ,   2'd0, 2'd2, 8'd9);
        r[7] = encode(OP_LDI,  2'd1, 2'd0, 8'h5A);
        r[8] = encode(OP_HALT, 2'd0, 2'd0, 8'h00);
        r[9] = encode(OP_LDI,  2'd1, 2'd0, 8'h99);
        return r;
    endfunction

    localparam rom_t ISA_ROM = isa_rom();

    puc_cpu dut (
        .clock          (clock),
        .isReset        (isReset),
        .switch         (switch),
        .register1Value (register1Value)
    );

    puc_cpu #(.ROM(ISA_ROM)) dut_isa (
        .clock          (clock),
        .isReset        (isa_reset),
        .switch         (isa_switch),
        .register1Value (isa_r1)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        if (isReset) begin
            m_edges = 0;
            m_r1    = 8'd0;
        end else begin
            m_edges++;
            if (m_edges >= 3 && (m_edges - 3) % 4 == 0) m_dir = switch;
            if (m_edges >= 5 && (m_edges - 5) % 4 == 0) m_r1 = m_dir ? m_r1 - 8'd1 : m_r1 + 8'd1;
        end
        @(negedge clock);
        check(tag, 32'(register1Value), 32'(m_r1));
    endtask

    logic [7:0] isa_exp_r1 [10] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                                   8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    logic [3:0] isa_exp_pc [10] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7,
                                   4'd8, 4'd8, 4'd8, 4'd8, 4'd8};

    initial begin
        @(negedge clock);

        // Reset for one edge.
        isReset = 1'b1;
        step("reset_r1");
        check("reset_pc", 32'(dut.pc), 32'd0);
        isReset = 1'b0;

        // Count up: first increment lands on the 5th edge after release.
        for (int i = 0; i < 4; i++) step("up_pre");
        check("first_zero", 32'(register1Value), 32'd0);
        step("up_first");
        check("first_inc", 32'(register1Value), 32'd1);
        for (int i = 5; i < 15; i++) step("up");
        check("up_15_edges", 32'(register1Value), 32'd3);

        // Count down, then back up.
        switch = 1'b1;
        for (int i = 0; i < 15; i++) step("down");
        switch = 1'b0;
        for (int i = 0; i < 18; i++) step("up_again");

        // Down phase starting from zero wraps to 255.
        isReset = 1'b1;
        step("reset2_r1");
        isReset = 1'b0;
        switch  = 1'b1;
        for (int i = 0; i < 5; i++) step("down_from_zero");
        check("wrap_255", 32'(register1Value), 32'd255);
        for (int i = 0; i < 8; i++) step("down_more");

        // Mid-run reset: value clears and timing restarts like the first run.
        switch = 1'b0;
        for (int i = 0; i < 3; i++) step("pre_midreset");
        isReset = 1'b1;
        step("midreset_r1");
        check("midreset_pc", 32'(dut.pc), 32'd0);
        isReset = 1'b0;
        for (int i = 0; i < 5; i++) step("restart");
        check("restart_inc", 32'(register1Value), 32'd1);

        // Randomized switch activity with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) switch = ~switch;
            isReset = ($urandom_range(0, 49) == 0);
            step("random");
        end
        isReset = 1'b0;

        // Directed ISA program: ADDI wrap, JZ taken / not taken, HALT.
        isa_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("isa_r1_%0d", i), 32'(isa_r1), 32'(isa_exp_r1[i]));
            check($sformatf("isa_pc_%0d", i), 32'(dut_isa.pc), 32'(isa_exp_pc[i]));
        end
        check("isa_r2", 32'(dut_isa.regs[2]), 32'd1);
        check("isa_r0", 32'(dut_isa.regs[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
